// File: rtl/mem_sram_slave.sv
// Flop-backed memory slave on the req/gnt/rvalid bus: fixed-latency in-order responses, throttled grants.
// Optional MEM_SRAM_SLAVE_RDATA_HOLD_EN keeps the last response on data_rdata between rvalid pulses.
module mem_sram_slave #(
    parameter int unsigned ADDRESS_SIZE = 64,
    parameter int unsigned DATA_WIDTH   = 64,
    parameter int unsigned NUM_WORDS    = 256,
    parameter int unsigned LATENCY      = 2,
    parameter int unsigned GNT_GAP      = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDRESS_SIZE-1:0]   address,
    input  logic [DATA_WIDTH-1:0]     data_wdata,
    input  logic                      data_req,
    input  logic                      data_we,
    input  logic [DATA_WIDTH/8-1:0]   data_be,
    output logic                      data_gnt,
    output logic                      data_rvalid,
    output logic [DATA_WIDTH-1:0]     data_rdata
);

    localparam int unsigned NBYTES = DATA_WIDTH / 8;
    localparam int unsigned OFF    = $clog2(NBYTES);
    localparam int unsigned IDX    = $clog2(NUM_WORDS);

    typedef struct packed {
        logic                  valid;
        logic                  is_write;
        logic [DATA_WIDTH-1:0] data;
    } resp_t;

    logic [DATA_WIDTH-1:0] mem_q [NUM_WORDS];
    resp_t                 pipe_q [LATENCY];
    resp_t                 pipe_d [LATENCY];
    logic [2:0]            gap_q, gap_d;
    logic [IDX-1:0]        idx;
    logic                  hs;
    resp_t                 out;
    logic [DATA_WIDTH-1:0] resp_data;
    logic                  unused_addr;

    // Upper and sub-word address bits are intentionally ignored (wrap-around addressing).
    assign unused_addr = ^address;
    assign idx         = address[OFF +: IDX];
    assign data_gnt    = data_req && (gap_q == '0) && !rst;
    assign hs          = data_gnt;

    always_comb begin
        gap_d = gap_q;
        if (hs) begin
            gap_d = 3'(GNT_GAP);
        end else if (gap_q != '0) begin
            gap_d = gap_q - 3'd1;
        end
    end

    always_comb begin
        pipe_d[0].valid    = hs;
        pipe_d[0].is_write = hs && data_we;
        pipe_d[0].data     = hs ? mem_q[idx] : '0;
        for (int unsigned i = 1; i < LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gap_q <= '0;
            for (int unsigned i = 0; i < LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            gap_q <= gap_d;
            for (int unsigned i = 0; i < LATENCY; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    // Storage is not reset; reads sample the pre-write value at the handshake edge.
    always_ff @(posedge clk) begin
        if (hs && data_we) begin
            for (int unsigned b = 0; b < NBYTES; b++) begin
                if (data_be[b]) begin
                    mem_q[idx][8*b +: 8] <= data_wdata[8*b +: 8];
                end
            end
        end
    end

    assign out         = pipe_q[LATENCY-1];
    assign data_rvalid = out.valid;
    assign resp_data   = (out.valid && !out.is_write) ? out.data : '0;

`ifdef MEM_SRAM_SLAVE_RDATA_HOLD_EN
    logic [DATA_WIDTH-1:0] hold_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q <= '0;
        end else if (out.valid) begin
            hold_q <= resp_data;
        end
    end

    assign data_rdata = out.valid ? resp_data : hold_q;
`else
    assign data_rdata = resp_data;
`endif

endmodule

// File: tb/tb_mem_sram_slave.sv
// Scoreboard bench for mem_sram_slave: four instances with different LATENCY/GNT_GAP, driven by directed vectors.
module tb_mem_sram_slave;

    localparam int unsigned N = 4;

    function automatic int unsigned lat_of(int unsigned k);
        case (k)
            0: return 2;
            1: return 2;
            2: return 4;
            default: return 3;
        endcase
    endfunction

    function automatic int unsigned gap_of(int unsigned k);
        return (k == 1) ? 2 : 0;
    endfunction

    typedef struct {
        int unsigned inst;
        logic [63:0] data;
        int unsigned due;
    } exp_t;

    logic        clk = 1'b0;
    int unsigned cyc = 0;
    int unsigned total = 0;
    int unsigned bad = 0;

    logic [N-1:0] rst_v, req_v, we_v, gnt_v, rvalid_v, exp_gnt_v;
    logic [63:0]  addr_v  [N];
    logic [63:0]  wdata_v [N];
    logic [63:0]  rdata_v [N];
    logic [7:0]   be_v    [N];

    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar k = 0; k < N; k++) begin : g_dut
        mem_sram_slave #(
            .ADDRESS_SIZE (64),
            .DATA_WIDTH   (64),
            .NUM_WORDS    (256),
            .LATENCY      (lat_of(k)),
            .GNT_GAP      (gap_of(k))
        ) u_dut (
            .clk         (clk),
            .rst         (rst_v[k]),
            .address     (addr_v[k]),
            .data_wdata  (wdata_v[k]),
            .data_req    (req_v[k]),
            .data_we     (we_v[k]),
            .data_be     (be_v[k]),
            .data_gnt    (gnt_v[k]),
            .data_rvalid (rvalid_v[k]),
            .data_rdata  (rdata_v[k])
        );
    end

    // Monitor: checks grants every cycle and pops the scoreboard on every rvalid.
    always @(negedge clk) begin
        for (int unsigned k = 0; k < N; k++) begin
            total++;
            if (gnt_v[k] !== exp_gnt_v[k]) begin
                bad++;
                $display("FAIL gnt inst=%0d cycle=%0d got=%b want=%b", k, cyc, gnt_v[k], exp_gnt_v[k]);
            end
            if (rvalid_v[k] === 1'b1) begin
                int idx;
                idx = -1;
                for (int i = 0; i < sb.size() && idx < 0; i++) begin
                    if (sb[i].inst == k) idx = i;
                end
                total++;
                if (idx < 0) begin
                    bad++;
                    $display("FAIL rvalid_unexpected inst=%0d cycle=%0d got rvalid=1 want 0", k, cyc);
                end else begin
                    if (rdata_v[k] !== sb[idx].data || cyc != sb[idx].due) begin
                        bad++;
                        $display("FAIL resp inst=%0d got data=%h cycle=%0d want data=%h cycle=%0d",
                                 k, rdata_v[k], cyc, sb[idx].data, sb[idx].due);
                    end
                    sb.delete(idx);
                end
            end else begin
`ifndef MEM_SRAM_SLAVE_RDATA_HOLD_EN
                total++;
                if (rdata_v[k] !== 64'h0) begin
                    bad++;
                    $display("FAIL rdata_idle inst=%0d cycle=%0d got=%h want=0", k, cyc, rdata_v[k]);
                end
`endif
                total++;
                if (rvalid_v[k] !== 1'b0) begin
                    bad++;
                    $display("FAIL rvalid_x inst=%0d cycle=%0d got=%b want=0", k, cyc, rvalid_v[k]);
                end
            end
        end
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due < cyc) begin
                total++;
                bad++;
                $display("FAIL resp_missing inst=%0d got no rvalid by cycle=%0d want data=%h at cycle=%0d",
                         sb[i].inst, cyc, sb[i].data, sb[i].due);
                sb.delete(i);
            end
        end
    end

    task automatic issue(input int unsigned k, input logic we, input logic [63:0] a,
                         input logic [63:0] d, input logic [7:0] be, input logic eg,
                         input logic [63:0] er);
        exp_t e;
        req_v[k]     = 1'b1;
        we_v[k]      = we;
        addr_v[k]    = a;
        wdata_v[k]   = d;
        be_v[k]      = be;
        exp_gnt_v[k] = eg;
        if (eg) begin
            e.inst = k;
            e.data = er;
            e.due  = cyc + lat_of(k);
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drop(input int unsigned k);
        req_v[k]     = 1'b0;
        exp_gnt_v[k] = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached got running want finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_v     = '1;
        req_v     = '1;
        we_v      = '0;
        exp_gnt_v = '0;
        for (int k = 0; k < N; k++) begin
            addr_v[k]  = '0;
            wdata_v[k] = '0;
            be_v[k]    = '0;
        end
        @(posedge clk); @(posedge clk); #1;
        rst_v = '0;
        req_v = '0;
        @(posedge clk); #1;

        // Instance 0: LATENCY=2, GNT_GAP=0
        issue(0, 1, 64'h10,  64'hDEADBEEF_CAFEF00D, 8'hFF, 1, 64'h0);
        issue(0, 0, 64'h10,  64'h0,                 8'h00, 1, 64'hDEADBEEF_CAFEF00D);
        issue(0, 1, 64'h20,  64'h1111_1111_1111_1111, 8'hFF, 1, 64'h0);
        issue(0, 1, 64'h20,  64'hAAAA_AAAA_AAAA_AAAA, 8'h0F, 1, 64'h0);
        issue(0, 0, 64'h20,  64'h0,                 8'h00, 1, 64'h1111_1111_AAAA_AAAA);
        issue(0, 1, 64'h800, 64'h55,                8'hFF, 1, 64'h0);
        issue(0, 0, 64'h0,   64'h0,                 8'h00, 1, 64'h55);
        issue(0, 0, 64'h803, 64'h0,                 8'h00, 1, 64'h55);
        issue(0, 1, 64'h10,  64'h0,                 8'h00, 1, 64'h0);
        issue(0, 0, 64'h17,  64'h0,                 8'h00, 1, 64'hDEADBEEF_CAFEF00D);
        issue(0, 1, 64'h7F8, 64'h0123_4567_89AB_CDEF, 8'hFF, 1, 64'h0);
        issue(0, 0, 64'hFF8, 64'h0,                 8'h00, 1, 64'h0123_4567_89AB_CDEF);
        issue(0, 0, 64'hF000_0000_0000_07F8, 64'h0, 8'h00, 1, 64'h0123_4567_89AB_CDEF);
        drop(0);

        // Instance 1: LATENCY=2, GNT_GAP=2; preload, then hold req for 9 cycles
        issue(1, 1, 64'h30, 64'hA1A1_0000_0000_0001, 8'hFF, 1, 64'h0);
        drop(1); drop(1);
        issue(1, 1, 64'h38, 64'hB2B2_0000_0000_0002, 8'hFF, 1, 64'h0);
        drop(1); drop(1);
        issue(1, 1, 64'h40, 64'hC3C3_0000_0000_0003, 8'hFF, 1, 64'h0);
        drop(1); drop(1);
        issue(1, 0, 64'h30, 64'h0, 8'h00, 1, 64'hA1A1_0000_0000_0001);
        issue(1, 0, 64'h38, 64'h0, 8'h00, 0, 64'h0);
        issue(1, 0, 64'h38, 64'h0, 8'h00, 0, 64'h0);
        issue(1, 0, 64'h38, 64'h0, 8'h00, 1, 64'hB2B2_0000_0000_0002);
        issue(1, 0, 64'h40, 64'h0, 8'h00, 0, 64'h0);
        issue(1, 0, 64'h40, 64'h0, 8'h00, 0, 64'h0);
        issue(1, 0, 64'h40, 64'h0, 8'h00, 1, 64'hC3C3_0000_0000_0003);
        issue(1, 0, 64'h48, 64'h0, 8'h00, 0, 64'h0);
        issue(1, 0, 64'h48, 64'h0, 8'h00, 0, 64'h0);
        drop(1);
        issue(1, 0, 64'h38, 64'h0, 8'h00, 1, 64'hB2B2_0000_0000_0002);
        drop(1);

        // Instance 2: LATENCY=4, back-to-back writes then reads
        for (int unsigned i = 0; i < 4; i++)
            issue(2, 1, 64'(8 * i), 64'h5000_0000_0000_0000 + 64'(i), 8'hFF, 1, 64'h0);
        for (int unsigned i = 0; i < 4; i++)
            issue(2, 0, 64'(8 * i), 64'h0, 8'h00, 1, 64'h5000_0000_0000_0000 + 64'(i));
        drop(2);

        // Instance 3: LATENCY=3, reset with two reads in flight
        issue(3, 1, 64'h40, 64'h7777_0000_1234_5678, 8'hFF, 1, 64'h0);
        issue(3, 1, 64'h48, 64'h8888_0000_9ABC_DEF0, 8'hFF, 1, 64'h0);
        drop(3); drop(3); drop(3);
        issue(3, 0, 64'h40, 64'h0, 8'h00, 1, 64'h7777_0000_1234_5678);
        issue(3, 0, 64'h48, 64'h0, 8'h00, 1, 64'h8888_0000_9ABC_DEF0);
        rst_v[3]     = 1'b1;
        req_v[3]     = 1'b1;
        we_v[3]      = 1'b0;
        addr_v[3]    = 64'h40;
        exp_gnt_v[3] = 1'b0;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].inst == 3) sb.delete(i);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_v[3] = 1'b0;
        issue(3, 0, 64'h40, 64'h0, 8'h00, 1, 64'h7777_0000_1234_5678);
        issue(3, 0, 64'h48, 64'h0, 8'h00, 1, 64'h8888_0000_9ABC_DEF0);
        drop(3);

        repeat (10) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
